// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM state encoding and request legality decode for the LSU.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Unsigned variants are load-only; halfwords need even, words need zero offset.
  function automatic logic req_illegal(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] offset);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = we;
      F3_H:    bad = offset[0];
      F3_HU:   bad = we | offset[0];
      F3_W:    bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - CPU request/response and data-memory signals of the LSU.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_we;
  logic [31:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_din, mem_we
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed lane of a memory word and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_dout,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  assign shifted = mem_dout >> {offset, 3'b000};

  always_comb begin
    rdata = mem_dout;
    case (funct3)
      F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata = {24'd0, shifted[7:0]};
      F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata = {16'd0, shifted[15:0]};
      default: rdata = mem_dout;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - single-outstanding load/store initiator for a byte-enabled synchronous memory.
// Optional LSU_RANGE_CHECK_EN: addresses >= MEM_BYTES are rejected as errors.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

`ifdef LSU_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  state_t      state, state_next;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic        err_q;
  logic        accept;
  logic        illegal;
  logic [1:0]  offset;
  logic [3:0]  st_we;
  logic [31:0] st_din;
  logic [31:0] aligned;

  assign offset  = bus.req_addr[1:0];
  assign accept  = bus.req_valid && (state == S_IDLE);
  assign illegal = req_illegal(bus.req_we, bus.req_funct3, offset)
                 || (RANGE_CHECK && (bus.req_addr >= 32'(MEM_BYTES)));

  // Write data is replicated into every lane so the byte enables alone pick the target.
  always_comb begin
    st_we  = 4'b1111;
    st_din = bus.req_wdata;
    case (bus.req_funct3)
      F3_B: begin
        st_we  = 4'b0001 << offset;
        st_din = {4{bus.req_wdata[7:0]}};
      end
      F3_H: begin
        st_we  = 4'b0011 << offset;
        st_din = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        st_we  = 4'b1111;
        st_din = bus.req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = illegal ? S_RESP : S_ACCESS;
      S_ACCESS: state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q        <= 2'b00;
      f3_q         <= 3'b000;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      bus.mem_addr <= 32'd0;
      bus.mem_din  <= 32'd0;
      bus.mem_we   <= 4'b0000;
    end else if (accept) begin
      off_q        <= offset;
      f3_q         <= bus.req_funct3;
      we_q         <= bus.req_we;
      err_q        <= illegal;
      bus.mem_addr <= {bus.req_addr[31:2], 2'b00};
      bus.mem_din  <= st_din;
      bus.mem_we   <= (bus.req_we && !illegal) ? st_we : 4'b0000;
    end else if (state == S_ACCESS) begin
      bus.mem_we   <= 4'b0000;
    end
  end

  lsu_load_align u_align (
    .mem_dout (bus.mem_dout),
    .offset   (off_q),
    .funct3   (f3_q),
    .rdata    (aligned)
  );

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_err   = (state == S_RESP) && err_q;
  assign bus.rsp_rdata = ((state == S_RESP) && !err_q && !we_q) ? aligned : 32'd0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl with a 1-cycle synchronous memory model.
module tb_lsu_mem_ctrl;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  bit    we_seen = 1'b0;
  exp_t  sb[$];
  logic [31:0] mem [0:1023];

  lsu_if bus ();

  lsu_mem_ctrl #(.MEM_BYTES(4096)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: byte-enabled write and registered read of the old word.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.mem_we[i]) mem[bus.mem_addr[11:2]][8*i +: 8] <= bus.mem_din[8*i +: 8];
    bus.mem_dout <= mem[bus.mem_addr[11:2]];
  end

  always @(negedge clk) if (bus.mem_we != 4'b0000) we_seen = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response strobe must match the oldest expectation, including its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_rdata"}, bus.rsp_rdata, e.rdata);
          chk({e.name, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});
          chk({e.name, "_cycle"}, cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req_ready !== 1'b1 && n < 8);
    if (bus.req_ready !== 1'b1) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic do_req(input string name, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input bit exp_err,
                        input logic [3:0] exp_we, input logic [31:0] exp_din,
                        input bit poke);
    exp_t e;
    wait_idle(name);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    we_seen        = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    e.name  = name;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = cyc + (exp_err ? 0 : 1);
    sb.push_back(e);
    if (!exp_err) begin
      chk({name, "_mem_we"}, {28'd0, bus.mem_we}, {28'd0, exp_we});
      chk({name, "_mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
      if (we) chk({name, "_mem_din"}, bus.mem_din, exp_din);
    end
    if (poke) begin
      // A store offered while busy must be dropped, not queued.
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h40;
      bus.req_wdata  = 32'hA5A5A5A5;
      chk({name, "_busy_ready"}, {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
    end
    wait_idle(name);
    if (exp_err) chk({name, "_no_we"}, {31'd0, we_seen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_din", bus.mem_din, 32'd0);
    chk("rst_mem_we", {28'd0, bus.mem_we}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    rst = 1'b0;

    do_req("sw_10",  1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF, 0);
    do_req("lw_10",  0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 4'b0000, 32'h0, 0);
    do_req("lh_12",  0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 4'b0000, 32'h0, 0);
    do_req("lbu_11", 0, 3'b100, 32'h11, 32'h0,        32'h000000BE, 0, 4'b0000, 32'h0, 1);
    do_req("lw_40",  0, 3'b010, 32'h40, 32'h0,        32'h00000000, 0, 4'b0000, 32'h0, 0);
    do_req("sb_13",  1, 3'b000, 32'h13, 32'h80,       32'h0,        0, 4'b1000, 32'h80808080, 0);
    do_req("lb_13",  0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 0, 4'b0000, 32'h0, 0);
    do_req("lbu_13", 0, 3'b100, 32'h13, 32'h0,        32'h00000080, 0, 4'b0000, 32'h0, 0);
    do_req("lw_10b", 0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 0, 4'b0000, 32'h0, 0);
    do_req("sh_22",  1, 3'b001, 32'h22, 32'h8001,     32'h0,        0, 4'b1100, 32'h80018001, 0);
    do_req("lh_22",  0, 3'b001, 32'h22, 32'h0,        32'hFFFF8001, 0, 4'b0000, 32'h0, 0);
    do_req("lhu_22", 0, 3'b101, 32'h22, 32'h0,        32'h00008001, 0, 4'b0000, 32'h0, 0);
    do_req("lw_06",  0, 3'b010, 32'h06, 32'h0,        32'h0,        1, 4'b0000, 32'h0, 0);
    do_req("sh_05",  1, 3'b001, 32'h05, 32'h1234,     32'h0,        1, 4'b0000, 32'h0, 0);
    do_req("f3_011", 0, 3'b011, 32'h00, 32'h0,        32'h0,        1, 4'b0000, 32'h0, 0);
    do_req("sbu_00", 1, 3'b100, 32'h00, 32'hFF,       32'h0,        1, 4'b0000, 32'h0, 0);

    // Reset in the middle of a store's ACCESS cycle.
    wait_idle("rst_mid");
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h30;
    bus.req_wdata  = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("rst_mid_we_before", {28'd0, bus.mem_we}, 32'hF);
    rst = 1'b1;
    #1;
    chk("rst_mid_we_cleared", {28'd0, bus.mem_we}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
    do_req("lw_30",  0, 3'b010, 32'h30, 32'h0,        32'h0,        0, 4'b0000, 32'h0, 0);

`ifdef LSU_RANGE_CHECK_EN
    do_req("sw_1000", 1, 3'b010, 32'h1000, 32'h12345678, 32'h0,     1, 4'b0000, 32'h0, 0);
    do_req("lw_00",   0, 3'b010, 32'h0,    32'h0,        32'h0,     0, 4'b0000, 32'h0, 0);
`else
    do_req("sw_1000", 1, 3'b010, 32'h1000, 32'h12345678, 32'h0,     0, 4'b1111, 32'h12345678, 0);
    do_req("lw_00",   0, 3'b010, 32'h0,    32'h0,        32'h12345678, 0, 4'b0000, 32'h0, 0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
